mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Two-port request/grant arbiter and sequencer in front of the 32x8 synchronous data memory.
//   Shares the single memory port between port 0 (instruction fetch) and port 1 (load/store unit).
//   Drives the memory rd/wr/addr/data_in signals from registers, and returns read data with a done pulse.
//   Sits between the CPU control path and the memory instance.
// PARAMETERS
//   AW          5   address width (32 locations)
//   DW          8   data width
//   FIXED_PRIO  0   0 = round-robin between ports; 1 = port 0 always wins a tie
// PORTS
//   clk           in   1    clock, all logic on rising edge
//   rst           in   1    synchronous reset, active-high
//   p0_req/p1_req in   1    access request; held with we/addr/wdata until gnt seen high
//   p0_we/p1_we   in   1    1 = write, 0 = read
//   p0_addr/p1_addr   in   AW   access address
//   p0_wdata/p1_wdata in   DW   write data
//   p0_gnt/p1_gnt in/out: out  1    request accepted this cycle (Mealy, single-cycle pulse)
//   p0_done/p1_done   out  1    access complete; for reads, rdata valid this cycle only
//   p0_rdata/p1_rdata out  DW   = mem_data_out; meaningful only with matching done
//   mem_addr      out  AW   registered address to memory
//   mem_data_in   out  DW   registered write data to memory
//   mem_rd        out  1    registered read enable, one cycle per read
//   mem_wr        out  1    registered write enable, one cycle per write
//   mem_data_out  in   DW   read data from memory (valid the cycle after mem_rd)
//   busy          out  1    state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, mem_rd=mem_wr=0, mem_addr=0, mem_data_in=0, last=1, gnt=0, done=0; gnt forced 0 while rst.
//   FSM states: IDLE, ISSUE, RESP.
//   - IDLE/RESP: if any req, then pick winner, assert gnt[w] and latch addr/wdata/we.
//     mem_rd = ~we, mem_wr = we, owner = w, last = w; next state ISSUE. If no req, next state IDLE.
//   - ISSUE: mem_rd/mem_wr high for exactly this cycle; memory acts at its end; never grant.
//     Next edge: clear mem_rd/mem_wr; state = RESP.
//   - RESP: done[owner] = 1 (reads and writes); rdata = mem_data_out.
//     A new grant in the same cycle is allowed (see IDLE/RESP rule).
//   Timing: gnt at T, mem_rd/wr at T+1, done and rdata at T+2. Sustained throughput: 1 access per 2 cycles.
//   Arbitration: single req wins outright.
//     Both req: FIXED_PRIO=0 grants port != last; FIXED_PRIO=1 grants port 0.
//     last=1 at reset, so port 0 wins the first tie.
//   Invariants: mem_rd & mem_wr never both 1; at most one gnt and one done per cycle; owner stable ISSUE->RESP.
//   Boundaries: addr 0 and 2^AW-1 pass unmodified (no wrap logic).
//     A req dropped before gnt is simply not serviced.
//   Reset mid-operation:
//     - A write whose mem_wr is already high in ISSUE completes in memory, but no done is issued.
//     - A read in ISSUE/RESP is abandoned; no done is issued.
//     - State returns to IDLE the cycle after rst.
// STRUCTURE
//   mem_arb_defs.vh: state encodings (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2), AW/DW defaults shared with memory.
//   Sub-module rr_arb2: 2-input round-robin picker (req[1:0], last, fixed_prio -> grant one-hot).
//   Top holds the FSM, owner/last registers, and the memory-side output registers.
// TESTING
//   1. Write then read: p1 writes addr 5 data 0xA5 (gnt@T, mem_wr&addr=5@T+1, p1_done@T+2).
//      p1 then reads addr 5 -> p1_done@+2, p1_rdata=0xA5.
//   2. Tie after reset: p0 reads 0, p1 reads 31 at the same cycle -> p0_gnt@T, p1_gnt@T+2 (RESP), p1_done@T+4.
//   3. Both req held 8 accesses: FIXED_PRIO=0 -> grants alternate 0,1,0,1 every 2 cycles.
//      FIXED_PRIO=1 -> port 0 only, port 1 starved.
//   4. Back-to-back via RESP-grant: p0 write 31=0xFF, then p0 read 31 granted in RESP cycle -> rdata=0xFF.
//      Check addr 0 = 0x00 the same way.
//   5. rst asserted during ISSUE of a read -> no done, mem_rd=0 next cycle, busy=0; next tie grants p0.
//   6. Random traffic vs reference model: read data matches model; assertion mem_rd&mem_wr==0 every cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter slice.
// Holds the FSM state encoding and the address/data width defaults
// that the arbiter, its interface and the 32x8 memory agree on.
package mem_arbiter_pkg;

  localparam int unsigned AW_DEF = 5;
  localparam int unsigned DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of every non-clock/reset signal of mem_arbiter.
//   p0_* / p1_*  : request/grant/done handshakes of fetch (0) and load/store (1)
//   mem_*        : registered memory-side controls plus returned read data
//   busy         : arbiter not idle
// slave  = arbiter view, master = CPU + memory view.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) ();

  logic          p0_req,   p1_req;
  logic          p0_we,    p1_we;
  logic [AW-1:0] p0_addr,  p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt,   p1_gnt;
  logic          p0_done,  p1_done;
  logic [DW-1:0] p0_rdata, p1_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_data_out;
  logic          busy;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p0_gnt, p0_done, p0_rdata,
    output p1_gnt, p1_done, p1_rdata,
    output mem_addr, mem_data_in, mem_rd, mem_wr,
    input  mem_data_out,
    output busy
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p0_gnt, p0_done, p0_rdata,
    input  p1_gnt, p1_done, p1_rdata,
    input  mem_addr, mem_data_in, mem_rd, mem_wr,
    output mem_data_out,
    input  busy
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-input picker.
//   req[1:0]   : pending requests
//   last       : port that won the previous grant
//   fixed_prio : 1 = port 0 wins ties, 0 = port != last wins ties
//   gnt[1:0]   : one-hot winner (zero when no request)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed_prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = (fixed_prio || last) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single port of the 32x8 synchronous data memory
// between instruction fetch (port 0) and the load/store unit (port 1).
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : mem_arbiter_if.slave (port handshakes, memory controls, busy)
// Timing: gnt (Mealy) at T, mem_rd/mem_wr at T+1, done/rdata at T+2.
// A new grant may be issued in the RESP cycle, giving 1 access per 2 cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  arb_state_t    state_q;
  logic          owner_q;
  logic          last_q;
  logic          done_q;
  logic          rd_q;
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;

  logic [1:0]    req;
  logic [1:0]    pick;
  logic          can_grant;
  logic          win;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign req = {bus.p1_req, bus.p0_req};

  rr_arb2 u_pick (
    .req        (req),
    .last       (last_q),
    .fixed_prio (FIXED_PRIO),
    .gnt        (pick)
  );

  assign can_grant = ((state_q == IDLE) || (state_q == RESP)) && !rst;
  assign win       = pick[1];
  assign sel_we    = win ? bus.p1_we    : bus.p0_we;
  assign sel_addr  = win ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = win ? bus.p1_wdata : bus.p0_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (|req) begin
            addr_q  <= sel_addr;
            data_q  <= sel_wdata;
            rd_q    <= ~sel_we;
            wr_q    <= sel_we;
            owner_q <= win;
            last_q  <= win;
            state_q <= ISSUE;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          done_q  <= 1'b1;
          state_q <= RESP;
        end
        default: begin
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.p0_gnt = can_grant & pick[0];
  assign bus.p1_gnt = can_grant & pick[1];

  // done is registered but masked by rst so a RESP cycle caught by reset
  // reports nothing; the abandoned access never completes.
  assign bus.p0_done  = done_q & ~owner_q & ~rst;
  assign bus.p1_done  = done_q &  owner_q & ~rst;
  assign bus.p0_rdata = bus.mem_data_out;
  assign bus.p1_rdata = bus.mem_data_out;

  assign bus.mem_addr    = addr_q;
  assign bus.mem_data_in = data_q;
  assign bus.mem_rd      = rd_q;
  assign bus.mem_wr      = wr_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_load = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter_if ifa ();
  mem_arbiter_if ifb ();

  mem_arbiter #(.AW(5), .DW(8), .FIXED_PRIO(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mem_arbiter #(.AW(5), .DW(8), .FIXED_PRIO(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic [7:0] mema [32];
  logic [7:0] memb [32];

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // 32x8 synchronous memories: write at edge, read data valid the cycle after mem_rd
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) begin
        mema[i] <= init_val(i);
        memb[i] <= init_val(i);
      end
    end else begin
      if (ifa.mem_wr) mema[ifa.mem_addr] <= ifa.mem_data_in;
      if (ifa.mem_rd) ifa.mem_data_out <= mema[ifa.mem_addr];
      if (ifb.mem_wr) memb[ifb.mem_addr] <= ifb.mem_data_in;
      if (ifb.mem_rd) ifb.mem_data_out <= memb[ifb.mem_addr];
    end
  end

  task automatic idle_inputs();
    ifa.p0_req = 0; ifa.p0_we = 0; ifa.p0_addr = '0; ifa.p0_wdata = '0;
    ifa.p1_req = 0; ifa.p1_we = 0; ifa.p1_addr = '0; ifa.p1_wdata = '0;
    ifb.p0_req = 0; ifb.p0_we = 0; ifb.p0_addr = '0; ifb.p0_wdata = '0;
    ifb.p1_req = 0; ifb.p1_we = 0; ifb.p1_addr = '0; ifb.p1_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic r, input logic we,
                          input logic [4:0] a, input logic [7:0] d);
    if (p == 0) begin
      ifa.p0_req = r; ifa.p0_we = we; ifa.p0_addr = a; ifa.p0_wdata = d;
    end else begin
      ifa.p1_req = r; ifa.p1_we = we; ifa.p1_addr = a; ifa.p1_wdata = d;
    end
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1; mem_load = 1;
    step(); step();
    rst = 0; mem_load = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    ifa.p0_req = 1; ifa.p1_req = 1;
    step();
    sample();
    n_checks++; if (ifa.p0_gnt !== 1'b0 || ifa.p1_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b%b want 00", ifa.p1_gnt, ifa.p0_gnt); end
    n_checks++; if (ifa.mem_rd !== 1'b0 || ifa.mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_rdwr: got rd=%b wr=%b want 0", ifa.mem_rd, ifa.mem_wr); end
    n_checks++; if (ifa.mem_addr !== 5'd0 || ifa.mem_data_in !== 8'd0) begin n_fail++; $display("FAIL reset_addr_data: got %h/%h want 0/0", ifa.mem_addr, ifa.mem_data_in); end
    n_checks++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", ifa.busy); end
    n_checks++; if (ifa.p0_done !== 1'b0 || ifa.p1_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b%b want 00", ifa.p1_done, ifa.p0_done); end
    step();
    rst = 0;
    sample();
    n_checks++; if (ifa.p0_gnt !== 1'b1 || ifa.p1_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_first_tie: got %b%b want 01", ifa.p1_gnt, ifa.p0_gnt); end
    step();
    idle_inputs();
    step(); step();
  endtask

  task automatic test_write_read();
    reset_dut();
    set_port(1, 1, 1, 5'd5, 8'hA5);
    sample();
    n_checks++; if (ifa.p1_gnt !== 1'b1 || ifa.p0_gnt !== 1'b0) begin n_fail++; $display("FAIL wr_gnt: got %b%b want 10", ifa.p1_gnt, ifa.p0_gnt); end
    step(); idle_inputs(); sample();
    n_checks++; if (ifa.mem_wr !== 1'b1 || ifa.mem_rd !== 1'b0) begin n_fail++; $display("FAIL wr_issue: got wr=%b rd=%b want 1/0", ifa.mem_wr, ifa.mem_rd); end
    n_checks++; if (ifa.mem_addr !== 5'd5 || ifa.mem_data_in !== 8'hA5) begin n_fail++; $display("FAIL wr_addr_data: got %h/%h want 05/a5", ifa.mem_addr, ifa.mem_data_in); end
    n_checks++; if (ifa.busy !== 1'b1 || ifa.p1_done !== 1'b0) begin n_fail++; $display("FAIL wr_busy: got busy=%b done=%b want 1/0", ifa.busy, ifa.p1_done); end
    step(); sample();
    n_checks++; if (ifa.p1_done !== 1'b1 || ifa.p0_done !== 1'b0) begin n_fail++; $display("FAIL wr_done: got %b%b want 10", ifa.p1_done, ifa.p0_done); end
    step();
    set_port(1, 1, 0, 5'd5, 8'h00);
    sample();
    n_checks++; if (ifa.p1_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %b want 1", ifa.p1_gnt); end
    step(); idle_inputs(); sample();
    n_checks++; if (ifa.mem_rd !== 1'b1 || ifa.mem_addr !== 5'd5) begin n_fail++; $display("FAIL rd_issue: got rd=%b addr=%h want 1/05", ifa.mem_rd, ifa.mem_addr); end
    step(); sample();
    n_checks++; if (ifa.p1_done !== 1'b1 || ifa.p1_rdata !== 8'hA5) begin n_fail++; $display("FAIL rd_data: got done=%b data=%h want 1/a5", ifa.p1_done, ifa.p1_rdata); end
    step(); step();
  endtask

  task automatic test_tie();
    reset_dut();
    set_port(0, 1, 0, 5'd0, 8'h00);
    set_port(1, 1, 0, 5'd31, 8'h00);
    for (int c = 0; c < 5; c++) begin
      sample();
      n_checks++; if (ifa.p0_gnt !== (c == 0) || ifa.p1_gnt !== (c == 2)) begin n_fail++; $display("FAIL tie_gnt c=%0d: got %b%b", c, ifa.p1_gnt, ifa.p0_gnt); end
      n_checks++; if (ifa.p0_done !== (c == 2) || ifa.p1_done !== (c == 4)) begin n_fail++; $display("FAIL tie_done c=%0d: got %b%b", c, ifa.p1_done, ifa.p0_done); end
      if (c == 2) begin
        n_checks++; if (ifa.p0_rdata !== init_val(0)) begin n_fail++; $display("FAIL tie_rdata0: got %h want %h", ifa.p0_rdata, init_val(0)); end
      end
      if (c == 3) begin
        n_checks++; if (ifa.mem_addr !== 5'd31) begin n_fail++; $display("FAIL tie_addr31: got %h want 1f", ifa.mem_addr); end
      end
      if (c == 4) begin
        n_checks++; if (ifa.p1_rdata !== init_val(31)) begin n_fail++; $display("FAIL tie_rdata1: got %h want %h", ifa.p1_rdata, init_val(31)); end
      end
      step();
      if (c == 0) ifa.p0_req = 0;
      if (c == 2) ifa.p1_req = 0;
    end
    idle_inputs();
    step();
  endtask

  task automatic test_alternation();
    reset_dut();
    ifa.p0_req = 1; ifa.p0_addr = 5'd3; ifa.p1_req = 1; ifa.p1_addr = 5'd9;
    ifb.p0_req = 1; ifb.p0_addr = 5'd3; ifb.p1_req = 1; ifb.p1_addr = 5'd9;
    for (int c = 0; c < 16; c++) begin
      bit slot;
      bit a_g0, a_g1, a_d0;
      slot = (c % 2 == 0);
      a_g0 = slot && ((c / 2) % 2 == 0);
      a_g1 = slot && ((c / 2) % 2 == 1);
      a_d0 = slot && (c >= 2) && (((c - 2) / 2) % 2 == 0);
      sample();
      n_checks++; if (ifa.p0_gnt !== a_g0 || ifa.p1_gnt !== a_g1) begin n_fail++; $display("FAIL rr_gnt c=%0d: got %b%b want %b%b", c, ifa.p1_gnt, ifa.p0_gnt, a_g1, a_g0); end
      n_checks++; if (ifa.p0_done !== a_d0) begin n_fail++; $display("FAIL rr_done0 c=%0d: got %b want %b", c, ifa.p0_done, a_d0); end
      n_checks++; if (ifb.p0_gnt !== slot || ifb.p1_gnt !== 1'b0) begin n_fail++; $display("FAIL fixed_gnt c=%0d: got %b%b want 0%b", c, ifb.p1_gnt, ifb.p0_gnt, slot); end
      n_checks++; if (ifb.p1_done !== 1'b0) begin n_fail++; $display("FAIL fixed_starve c=%0d: got %b want 0", c, ifb.p1_done); end
      step();
    end
    idle_inputs();
    step(); step(); step();
  endtask

  task automatic test_resp_grant();
    logic [4:0] addrs [2];
    logic [7:0] datas [2];
    addrs[0] = 5'd31; datas[0] = 8'hFF;
    addrs[1] = 5'd0;  datas[1] = 8'h00;
    reset_dut();
    for (int k = 0; k < 2; k++) begin
      set_port(0, 1, 1, addrs[k], datas[k]);
      sample();
      n_checks++; if (ifa.p0_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_wgnt k=%0d: got %b want 1", k, ifa.p0_gnt); end
      step(); ifa.p0_req = 0; sample();
      n_checks++; if (ifa.mem_wr !== 1'b1 || ifa.mem_addr !== addrs[k]) begin n_fail++; $display("FAIL b2b_wissue k=%0d: got wr=%b addr=%h want 1/%h", k, ifa.mem_wr, ifa.mem_addr, addrs[k]); end
      step();
      set_port(0, 1, 0, addrs[k], 8'h00);
      sample();
      n_checks++; if (ifa.p0_gnt !== 1'b1 || ifa.p0_done !== 1'b1) begin n_fail++; $display("FAIL b2b_respgnt k=%0d: got gnt=%b done=%b want 1/1", k, ifa.p0_gnt, ifa.p0_done); end
      step(); ifa.p0_req = 0; sample();
      n_checks++; if (ifa.mem_rd !== 1'b1 || ifa.mem_addr !== addrs[k]) begin n_fail++; $display("FAIL b2b_rissue k=%0d: got rd=%b addr=%h want 1/%h", k, ifa.mem_rd, ifa.mem_addr, addrs[k]); end
      step(); sample();
      n_checks++; if (ifa.p0_done !== 1'b1 || ifa.p0_rdata !== datas[k]) begin n_fail++; $display("FAIL b2b_rdata k=%0d: got done=%b data=%h want 1/%h", k, ifa.p0_done, ifa.p0_rdata, datas[k]); end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    reset_dut();
    set_port(0, 1, 0, 5'd4, 8'h00);
    sample();
    n_checks++; if (ifa.p0_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_rgnt: got %b want 1", ifa.p0_gnt); end
    step(); ifa.p0_req = 0; sample();
    n_checks++; if (ifa.mem_rd !== 1'b1) begin n_fail++; $display("FAIL mid_rissue: got %b want 1", ifa.mem_rd); end
    rst = 1;
    step();
    rst = 0;
    ifa.p0_req = 1; ifa.p1_req = 1;
    sample();
    n_checks++; if (ifa.p0_done !== 1'b0 || ifa.mem_rd !== 1'b0 || ifa.busy !== 1'b0) begin n_fail++; $display("FAIL mid_rabort: got done=%b rd=%b busy=%b want 0/0/0", ifa.p0_done, ifa.mem_rd, ifa.busy); end
    n_checks++; if (ifa.p0_gnt !== 1'b1 || ifa.p1_gnt !== 1'b0) begin n_fail++; $display("FAIL mid_tie: got %b%b want 01", ifa.p1_gnt, ifa.p0_gnt); end
    step(); idle_inputs(); step(); step();
    set_port(1, 1, 1, 5'd7, 8'h3C);
    sample();
    n_checks++; if (ifa.p1_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_wgnt: got %b want 1", ifa.p1_gnt); end
    step(); ifa.p1_req = 0; sample();
    n_checks++; if (ifa.mem_wr !== 1'b1) begin n_fail++; $display("FAIL mid_wissue: got %b want 1", ifa.mem_wr); end
    rst = 1;
    step();
    rst = 0;
    sample();
    n_checks++; if (ifa.p1_done !== 1'b0 || ifa.busy !== 1'b0) begin n_fail++; $display("FAIL mid_wnodone: got done=%b busy=%b want 0/0", ifa.p1_done, ifa.busy); end
    step();
    set_port(1, 1, 0, 5'd7, 8'h00);
    sample();
    step(); idle_inputs(); step(); sample();
    n_checks++; if (ifa.p1_done !== 1'b1 || ifa.p1_rdata !== 8'h3C) begin n_fail++; $display("FAIL mid_wpersist: got done=%b data=%h want 1/3c", ifa.p1_done, ifa.p1_rdata); end
    step(); step();
  endtask

  typedef struct {
    int         port;
    bit         rd;
    logic [7:0] data;
    int         due;
  } exp_t;

  task automatic test_random();
    logic [7:0] mm [32];
    exp_t       q [$];
    exp_t       e;
    int         last_w, last_g, w;
    bit         gseen [2];
    bit         r0, r1, free, exp_g0, exp_g1, cur_req;
    reset_dut();
    for (int i = 0; i < 32; i++) mm[i] = init_val(i);
    last_w = 1; last_g = -10; gseen[0] = 0; gseen[1] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        cur_req = (p == 0) ? ifa.p0_req : ifa.p1_req;
        if (gseen[p] || (cur_req && $urandom_range(0, 15) == 0)) begin
          set_port(p, 0, 0, '0, '0);
          cur_req = 0;
        end
        if (!cur_req && $urandom_range(0, 2) == 0)
          set_port(p, 1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
      end
      sample();
      r0 = ifa.p0_req; r1 = ifa.p1_req;
      free = (c - last_g) >= 2;
      if (r0 && r1) w = (last_w == 0) ? 1 : 0;
      else          w = r1 ? 1 : 0;
      exp_g0 = free && (r0 || r1) && (w == 0);
      exp_g1 = free && (r0 || r1) && (w == 1);
      n_checks++; if (ifa.p0_gnt !== exp_g0 || ifa.p1_gnt !== exp_g1) begin n_fail++; $display("FAIL rand_gnt c=%0d: got %b%b want %b%b", c, ifa.p1_gnt, ifa.p0_gnt, exp_g1, exp_g0); end
      n_checks++; if ((ifa.mem_rd & ifa.mem_wr) !== 1'b0) begin n_fail++; $display("FAIL rand_rdwr c=%0d: got rd=%b wr=%b", c, ifa.mem_rd, ifa.mem_wr); end
      if (q.size() > 0 && q[0].due == c) begin
        e = q.pop_front();
        n_checks++; if (ifa.p0_done !== (e.port == 0) || ifa.p1_done !== (e.port == 1)) begin n_fail++; $display("FAIL rand_done c=%0d: got %b%b want port %0d", c, ifa.p1_done, ifa.p0_done, e.port); end
        if (e.rd) begin
          n_checks++;
          if (((e.port == 0) ? ifa.p0_rdata : ifa.p1_rdata) !== e.data) begin n_fail++; $display("FAIL rand_rdata c=%0d: got %h want %h", c, ifa.mem_data_out, e.data); end
        end
      end else begin
        n_checks++; if (ifa.p0_done !== 1'b0 || ifa.p1_done !== 1'b0) begin n_fail++; $display("FAIL rand_nodone c=%0d: got %b%b want 00", c, ifa.p1_done, ifa.p0_done); end
      end
      if (exp_g0 || exp_g1) begin
        logic       we;
        logic [4:0] a;
        logic [7:0] d;
        we = (w == 1) ? ifa.p1_we : ifa.p0_we;
        a  = (w == 1) ? ifa.p1_addr : ifa.p0_addr;
        d  = (w == 1) ? ifa.p1_wdata : ifa.p0_wdata;
        last_w = w; last_g = c;
        if (we) begin
          mm[a] = d;
          q.push_back('{port: w, rd: 1'b0, data: d, due: c + 2});
        end else begin
          q.push_back('{port: w, rd: 1'b1, data: mm[a], due: c + 2});
        end
      end
      gseen[0] = ifa.p0_gnt; gseen[1] = ifa.p1_gnt;
      step();
    end
    idle_inputs();
    step(); step(); step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_write_read();
    test_tie();
    test_alternation();
    test_resp_grant();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
